pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It sits beside the forwarding logic and covers every hazard forwarding cannot resolve: load-use dependencies, I-cache and D-cache miss stalls, and EX-stage control-flow redirects, including a redirect that arrives while a fetch is still outstanding. It drives the PC and pipeline-register write-enable and flush controls, plus the PC redirect mux select.

## Interface
Parameters:
- XLEN, 32, PC/target width
- CNT_W, 32, performance counter width (used only with HAZARD_STATS_EN)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegisterRd  in  5  load destination register
- IF_ID_RegisterRs1, IF_ID_RegisterRs2  in  5 each  source registers of the instruction in ID
- IF_ID_uses_rs1, IF_ID_uses_rs2  in  1 each  ID instruction actually reads that source
- EX_redirect  in  1  branch mispredict or jump resolved in EX
- EX_redirect_target  in  XLEN  correct next PC
- icache_stall  in  1  fetch not complete this cycle
- dcache_stall  in  1  memory access not complete this cycle
- pc_write  out  1  PC register load enable
- pc_sel_redirect  out  1  PC mux selects redirect_pc instead of PC+4
- redirect_pc  out  XLEN  target presented to the PC mux
- IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write  out  1 each  pipeline register enables
- IF_ID_flush, ID_EX_flush  out  1 each  load a bubble (NOP, all control bits 0)
- hz_state  out  1  0 = RUN, 1 = REDIRECT_WAIT (debug)

## Operation
Per-cycle priority is fixed. The highest-priority active condition defines the outputs. Defaults: all writes 1, flushes 0, pc_sel_redirect 0.
1. **dcache_stall.** Full freeze: pc_write and all *_write = 0, flushes 0. FSM state and latched target are held. A redirect or load-use condition present in the same cycle is ignored and re-evaluated next cycle, because the inputs are held too.
2. **EX_redirect, state RUN, icache_stall = 0.** pc_write = 1, pc_sel_redirect = 1, redirect_pc = EX_redirect_target (combinational pass-through), IF_ID_flush = 1, ID_EX_flush = 1.
3. **EX_redirect, state RUN, icache_stall = 1.** Latch the target into redirect_pc and go to REDIRECT_WAIT. This cycle: pc_write = 0, IF_ID_flush = 1, ID_EX_flush = 1.
4. **REDIRECT_WAIT.**
   - Every cycle: IF_ID_flush = 1, ID_EX_flush = 1. The wrong-path fetch in flight is discarded.
   - While icache_stall = 1: pc_write = 0.
   - First cycle icache_stall = 0: pc_write = 1, pc_sel_redirect = 1, return to RUN.
   - A new EX_redirect in this state cannot occur, because EX holds a bubble. Ignore it.
5. **Load-use.** Condition: ID_EX_MemRead & Rd ≠ 0 & ((Rd == Rs1 & uses_rs1) | (Rd == Rs2 & uses_rs2)). Response: pc_write = 0, IF_ID_write = 0, ID_EX_flush = 1. Exactly one bubble; the next cycle the load is in MEM and forwarding resolves the dependency. Load-use with icache_stall active: load-use wins.
6. **icache_stall only.** pc_write = 0, IF_ID_flush = 1; downstream stages advance.

Reset:
- While rst = 1: state = RUN, redirect_pc = 0, all *_write = 0, pc_write = 0, flushes = 0, pc_sel_redirect = 0.
- Asserting reset mid-REDIRECT_WAIT abandons the pending redirect.

## Timing
- All controls except state and the latched target are combinational from inputs and state within the cycle.
- State and redirect_pc update on posedge clk.
- Redirect with fetch ready: 2-bubble penalty, and the correct-path instruction enters IF the next cycle.
- Redirect with fetch busy: penalty = 2 + (remaining icache_stall cycles).
- Load-use: exactly 1 bubble per dependency; back-to-back load-use pairs give 1 bubble each.
- dcache_stall spanning N cycles adds exactly N cycles and leaves no extra bubble.

## Configuration
- HAZARD_STATS_EN defined: three CNT_W saturating counters, readable as outputs stat_loaduse, stat_redirect, stat_memstall.
  - stat_loaduse: load-use bubbles.
  - stat_redirect: redirect events, counted once per redirect, not per wait cycle.
  - stat_memstall: dcache_stall cycles.
  - All reset to 0.
- HAZARD_STATS_EN undefined: the stat ports and counters are absent.

## Structure
- Shared hazard_pkg holds:
  - the hz_state_t enum (RUN, REDIRECT_WAIT)
  - the NOP encoding constant 32'h00000013
  - the CNT_W default
- One sub-module, hazard_perf_counters, instantiated only under HAZARD_STATS_EN.

## Test plan
- **Load-use:** lw x5 in EX, ID add reads x5 (uses_rs1 = 1) -> one cycle with pc_write = 0, IF_ID_write = 0, ID_EX_flush = 1; next cycle all writes 1.
- **Load to x0:** lw x0 in EX, ID reads x0 -> no stall.
- **Redirect, fetch idle:** EX_redirect = 1 with target 0x0000_0100, icache_stall = 0 -> same cycle pc_write = 1, pc_sel_redirect = 1, redirect_pc = 0x100, both flushes 1.
- **Redirect during fetch miss:** EX_redirect with target 0x200 while icache_stall stays high 3 more cycles -> REDIRECT_WAIT, flushes 1 for all 4 cycles; in the cycle icache_stall falls, pc_write = 1 with redirect_pc = 0x200; then RUN.
- **D-cache stall over redirect:** dcache_stall = 1 for 5 cycles concurrent with EX_redirect -> all enables 0 for 5 cycles, then redirect handled on cycle 6.
- **Async reset mid-wait:** rst asserted mid-REDIRECT_WAIT -> state RUN and redirect_pc = 0 immediately; with HAZARD_STATS_EN, counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state type,
// the NOP encoding used for pipeline bubbles, counter width default and
// the load-use detection helper.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN           = 1'b0,
    REDIRECT_WAIT = 1'b1
  } hz_state_t;

  // addi x0, x0, 0 -- what a flushed pipeline register represents
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int unsigned CNT_W_DEFAULT = 32;

  // True when the load in EX writes a register the ID instruction reads.
  // Writes to x0 never create a dependency.
  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs1,
    input logic       uses_rs2
  );
    return mem_read && (rd != 5'd0) &&
           (((rd == rs1) && uses_rs1) || ((rd == rs2) && uses_rs2));
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating hazard event counters: load-use bubbles, redirect events and
// D-cache stall cycles. Only instantiated when HAZARD_STATS_EN is defined.
module hazard_perf_counters
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_loaduse,
  input  logic             inc_redirect,
  input  logic             inc_memstall,
  output logic [CNT_W-1:0] stat_loaduse,
  output logic [CNT_W-1:0] stat_redirect,
  output logic [CNT_W-1:0] stat_memstall
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Each counter increments on its event and sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loaduse  <= '0;
      stat_redirect <= '0;
      stat_memstall <= '0;
    end else begin
      if (inc_loaduse && (stat_loaduse != CNT_MAX))
        stat_loaduse <= stat_loaduse + 1'b1;
      if (inc_redirect && (stat_redirect != CNT_MAX))
        stat_redirect <= stat_redirect + 1'b1;
      if (inc_memstall && (stat_memstall != CNT_MAX))
        stat_memstall <= stat_memstall + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Handles load-use bubbles, I/D-cache miss stalls and EX-stage redirects,
// including a redirect that must wait for an outstanding fetch.
// Optional feature macro: HAZARD_STATS_EN adds saturating event counters
// (stat_loaduse, stat_redirect, stat_memstall).
//
// Handshake note: there is no valid/ready pair here; icache_stall and
// dcache_stall are level "not done" indications sampled every cycle, and
// all controls are combinational from the current inputs and state.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ID_EX_MemRead,
  input  logic [4:0]      ID_EX_RegisterRd,
  input  logic [4:0]      IF_ID_RegisterRs1,
  input  logic [4:0]      IF_ID_RegisterRs2,
  input  logic            IF_ID_uses_rs1,
  input  logic            IF_ID_uses_rs2,
  input  logic            EX_redirect,
  input  logic [XLEN-1:0] EX_redirect_target,
  input  logic            icache_stall,
  input  logic            dcache_stall,
  output logic            pc_write,
  output logic            pc_sel_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            IF_ID_write,
  output logic            ID_EX_write,
  output logic            EX_MEM_write,
  output logic            MEM_WB_write,
  output logic            IF_ID_flush,
  output logic            ID_EX_flush,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0] stat_loaduse,
  output logic [CNT_W-1:0] stat_redirect,
  output logic [CNT_W-1:0] stat_memstall,
`endif
  output logic            hz_state
);

  hz_state_t       state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            load_use;
  logic            ev_loaduse;
  logic            ev_redirect;
  logic            ev_memstall;

  assign load_use = load_use_hazard(ID_EX_MemRead, ID_EX_RegisterRd,
                                    IF_ID_RegisterRs1, IF_ID_RegisterRs2,
                                    IF_ID_uses_rs1, IF_ID_uses_rs2);

  assign hz_state = state_q;

  // Fixed-priority decode: reset, dcache freeze, pending redirect,
  // new redirect, load-use, icache stall, then free-running defaults.
  always_comb begin
    pc_write        = 1'b1;
    pc_sel_redirect = 1'b0;
    redirect_pc     = target_q;
    IF_ID_write     = 1'b1;
    ID_EX_write     = 1'b1;
    EX_MEM_write    = 1'b1;
    MEM_WB_write    = 1'b1;
    IF_ID_flush     = 1'b0;
    ID_EX_flush     = 1'b0;
    state_d         = state_q;
    target_d        = target_q;
    ev_loaduse      = 1'b0;
    ev_redirect     = 1'b0;
    ev_memstall     = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
    end else if (dcache_stall) begin
      // Whole pipeline frozen; inputs are held so anything else pending
      // is simply seen again once the stall clears.
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      ev_memstall  = 1'b1;
    end else if (state_q == REDIRECT_WAIT) begin
      // Discard the wrong-path fetch until the I-cache lets go, then load
      // the latched target. EX holds a bubble, so EX_redirect is ignored.
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      if (icache_stall) begin
        pc_write = 1'b0;
      end else begin
        pc_sel_redirect = 1'b1;
        state_d         = RUN;
      end
    end else if (EX_redirect) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      ev_redirect = 1'b1;
      if (!icache_stall) begin
        pc_sel_redirect = 1'b1;
        redirect_pc     = EX_redirect_target;
      end else begin
        pc_write = 1'b0;
        target_d = EX_redirect_target;
        state_d  = REDIRECT_WAIT;
      end
    end else if (load_use) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      ev_loaduse  = 1'b1;
    end else if (icache_stall) begin
      pc_write    = 1'b0;
      IF_ID_flush = 1'b1;
    end
  end

  // FSM state and latched redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

`ifdef HAZARD_STATS_EN
  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst           (rst),
    .inc_loaduse   (ev_loaduse),
    .inc_redirect  (ev_redirect),
    .inc_memstall  (ev_memstall),
    .stat_loaduse  (stat_loaduse),
    .stat_redirect (stat_redirect),
    .stat_memstall (stat_memstall)
  );
`endif

endmodule
